// File: rtl/rtype_exec_ctrl.sv
// R-type issue/writeback controller around an external ALU.
// Owns the register file, carry flag and retired-instruction counter.
module rtype_exec_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Instr_valid,
    input  logic [31:0]      Instr,
    output logic             Instr_ready,
    output logic [31:0]      Src_1,
    output logic [31:0]      Src_2,
    output logic [5:0]       OP_ctrl,
    input  logic [31:0]      ALU_Result,
    input  logic             ALU_Carry,
    output logic             Done,
    output logic             Illegal,
    output logic             Carry_flag,
    output logic [CNT_W-1:0] Instr_cnt,
    input  logic             Dbg_we,
    input  logic [4:0]       Dbg_addr,
    input  logic [31:0]      Dbg_wdata,
    output logic [31:0]      Dbg_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    localparam logic [5:0] F_ADDU = 6'b001001;
    localparam logic [5:0] F_SUBU = 6'b001010;

    state_t             state_q, state_d;
    logic [31:0]        rf_q [32];
    logic [31:0]        rf_d [32];
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        src1_q, src1_d;
    logic [31:0]        src2_q, src2_d;
    logic               illegal_q, illegal_d;
    logic [31:0]        res_q, res_d;
    logic               cres_q, cres_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [5:0] op_f, funct_f;
    logic [4:0] rs_f, rt_f, rd_f;
    logic       unused_shamt;

    assign op_f         = instr_q[31:26];
    assign rs_f         = instr_q[25:21];
    assign rt_f         = instr_q[20:16];
    assign rd_f         = instr_q[15:11];
    assign funct_f      = instr_q[5:0];
    assign unused_shamt = ^instr_q[10:6];

    // Handshake, ALU drive and status outputs
    always_comb begin
        Instr_ready = (state_q == IDLE);
        Done        = (state_q == WB);
        Illegal     = (state_q == WB) && illegal_q;
        OP_ctrl     = 6'b000000;
        if (state_q == EXEC && !illegal_q)
            OP_ctrl = funct_f;
        Src_1      = src1_q;
        Src_2      = src2_q;
        Carry_flag = carry_q;
        Instr_cnt  = cnt_q;
        Dbg_rdata  = (Dbg_addr == 5'd0) ? 32'd0 : rf_q[Dbg_addr];
    end

    // Next-state and datapath updates for the four-step sequence
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        illegal_d = illegal_q;
        res_d     = res_q;
        cres_d    = cres_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        for (int i = 0; i < 32; i++)
            rf_d[i] = rf_q[i];
        unique case (state_q)
            IDLE: begin
                if (Dbg_we && Dbg_addr != 5'd0)
                    rf_d[Dbg_addr] = Dbg_wdata;
                if (Instr_valid) begin
                    instr_d = Instr;
                    state_d = READ;
                end
            end
            READ: begin
                src1_d    = rf_q[rs_f];
                src2_d    = rf_q[rt_f];
                illegal_d = (op_f != 6'd0) ||
                            (funct_f != F_ADDU && funct_f != F_SUBU);
                state_d   = EXEC;
            end
            EXEC: begin
                res_d   = ALU_Result;
                cres_d  = ALU_Carry;
                state_d = WB;
            end
            WB: begin
                if (!illegal_q) begin
                    if (rd_f != 5'd0)
                        rf_d[rd_f] = res_q;
                    carry_d = cres_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rf_d[0] = 32'd0;
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= 32'd0;
            src1_q    <= 32'd0;
            src2_q    <= 32'd0;
            illegal_q <= 1'b0;
            res_q     <= 32'd0;
            cres_q    <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= 32'd0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            illegal_q <= illegal_d;
            res_q     <= res_d;
            cres_q    <= cres_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= rf_d[i];
        end
    end

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Directed bench for rtype_exec_ctrl with a small addu/subu ALU
// attached to its operand and op-code outputs.
module tb_rtype_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Instr_valid = 1'b0;
    logic [31:0] Instr = 32'd0;
    logic        Instr_ready;
    logic [31:0] Src_1, Src_2;
    logic [5:0]  OP_ctrl;
    logic [31:0] ALU_Result;
    logic        ALU_Carry;
    logic        Done, Illegal, Carry_flag;
    logic [15:0] Instr_cnt;
    logic        Dbg_we = 1'b0;
    logic [4:0]  Dbg_addr = 5'd0;
    logic [31:0] Dbg_wdata = 32'd0;
    logic [31:0] Dbg_rdata;

    int checks = 0;
    int errors = 0;

    rtype_exec_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .Instr_valid(Instr_valid), .Instr(Instr),
        .Instr_ready(Instr_ready),
        .Src_1(Src_1), .Src_2(Src_2), .OP_ctrl(OP_ctrl),
        .ALU_Result(ALU_Result), .ALU_Carry(ALU_Carry),
        .Done(Done), .Illegal(Illegal),
        .Carry_flag(Carry_flag), .Instr_cnt(Instr_cnt),
        .Dbg_we(Dbg_we), .Dbg_addr(Dbg_addr),
        .Dbg_wdata(Dbg_wdata), .Dbg_rdata(Dbg_rdata)
    );

    always #5 clk = ~clk;

    // Reference ALU: addu / subu, carry is bit 32 of the 33-bit result
    always_comb begin
        logic [32:0] w;
        w = 33'd0;
        if (OP_ctrl == 6'b001001)
            w = {1'b0, Src_1} + {1'b0, Src_2};
        else if (OP_ctrl == 6'b001010)
            w = {1'b0, Src_1} - {1'b0, Src_2};
        ALU_Result = w[31:0];
        ALU_Carry  = w[32];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
        Dbg_we = 1'b1; Dbg_addr = a; Dbg_wdata = d;
        tick();
        Dbg_we = 1'b0;
    endtask

    task automatic reg_chk(input string tag, input logic [4:0] a,
                           input logic [31:0] exp);
        Dbg_addr = a;
        #1;
        chk(tag, Dbg_rdata, exp);
    endtask

    // Full issue: accept, READ, EXEC, WB, back to IDLE
    task automatic issue(input string tag, input logic [31:0] w,
                         input logic [5:0] exp_op,
                         input logic exp_ill);
        Instr_valid = 1'b1; Instr = w;
        tick();
        Instr_valid = 1'b0;
        chk({tag, ".rdy_read"}, 32'(Instr_ready), 32'd0);
        chk({tag, ".op_read"}, 32'(OP_ctrl), 32'd0);
        tick();
        chk({tag, ".rdy_exec"}, 32'(Instr_ready), 32'd0);
        chk({tag, ".op_exec"}, 32'(OP_ctrl), 32'(exp_op));
        chk({tag, ".done_exec"}, 32'(Done), 32'd0);
        tick();
        chk({tag, ".rdy_wb"}, 32'(Instr_ready), 32'd0);
        chk({tag, ".done_wb"}, 32'(Done), 32'd1);
        chk({tag, ".ill_wb"}, 32'(Illegal), 32'(exp_ill));
        chk({tag, ".op_wb"}, 32'(OP_ctrl), 32'd0);
        tick();
        chk({tag, ".rdy_idle"}, 32'(Instr_ready), 32'd1);
        chk({tag, ".done_idle"}, 32'(Done), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst.ready", 32'(Instr_ready), 32'd1);
        chk("rst.done", 32'(Done), 32'd0);
        chk("rst.src1", Src_1, 32'd0);
        chk("rst.src2", Src_2, 32'd0);
        chk("rst.op", 32'(OP_ctrl), 32'd0);
        chk("rst.cnt", 32'(Instr_cnt), 32'd0);
        chk("rst.carry", 32'(Carry_flag), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        dbg_wr(5'd1, 32'd5);
        dbg_wr(5'd2, 32'd3);
        reg_chk("dbg.r1", 5'd1, 32'd5);
        reg_chk("dbg.r2", 5'd2, 32'd3);

        // addu $3,$1,$2
        issue("addu", 32'h0022_1809, 6'b001001, 1'b0);
        reg_chk("addu.r3", 5'd3, 32'd8);
        chk("addu.carry", 32'(Carry_flag), 32'd0);
        chk("addu.cnt", 32'(Instr_cnt), 32'd1);
        chk("addu.src1", Src_1, 32'd5);
        chk("addu.src2", Src_2, 32'd3);

        // subu $4,$2,$1 : 3 - 5 borrows
        issue("subu", 32'h0041_200A, 6'b001010, 1'b0);
        reg_chk("subu.r4", 5'd4, 32'hFFFF_FFFE);
        chk("subu.carry", 32'(Carry_flag), 32'd1);
        chk("subu.cnt", 32'(Instr_cnt), 32'd2);

        // addu $6,$5,$1 wraps
        dbg_wr(5'd5, 32'hFFFF_FFFF);
        issue("wrap", 32'h00A1_3009, 6'b001001, 1'b0);
        reg_chk("wrap.r6", 5'd6, 32'd4);
        chk("wrap.carry", 32'(Carry_flag), 32'd1);
        chk("wrap.cnt", 32'(Instr_cnt), 32'd3);

        // addu $0,$1,$2
        issue("rd0", 32'h0022_0009, 6'b001001, 1'b0);
        reg_chk("rd0.r0", 5'd0, 32'd0);
        chk("rd0.carry", 32'(Carry_flag), 32'd0);
        chk("rd0.cnt", 32'(Instr_cnt), 32'd4);
        dbg_wr(5'd0, 32'd7);
        reg_chk("dbg.r0", 5'd0, 32'd0);

        // funct 0 is illegal
        issue("ill", 32'h0022_1800, 6'b000000, 1'b1);
        reg_chk("ill.r3", 5'd3, 32'd8);
        chk("ill.carry", 32'(Carry_flag), 32'd0);
        chk("ill.cnt", 32'(Instr_cnt), 32'd4);

        // Back-pressure: valid held across two words
        Instr_valid = 1'b1; Instr = 32'h0022_3809;
        tick();
        Instr = 32'h0041_400A;
        chk("bp.rdy1", 32'(Instr_ready), 32'd0);
        tick();
        Dbg_we = 1'b1; Dbg_addr = 5'd9; Dbg_wdata = 32'h55;
        tick();
        Dbg_we = 1'b0;
        chk("bp.done1", 32'(Done), 32'd1);
        chk("bp.rdy_wb", 32'(Instr_ready), 32'd0);
        tick();
        chk("bp.rdy_idle", 32'(Instr_ready), 32'd1);
        chk("bp.nodone", 32'(Done), 32'd0);
        tick();
        Instr_valid = 1'b0;
        chk("bp.rdy2", 32'(Instr_ready), 32'd0);
        tick();
        tick();
        chk("bp.done2", 32'(Done), 32'd1);
        tick();
        reg_chk("bp.r7", 5'd7, 32'd8);
        reg_chk("bp.r9", 5'd9, 32'd0);
        reg_chk("bp.r8", 5'd8, 32'hFFFF_FFFE);
        chk("bp.cnt", 32'(Instr_cnt), 32'd6);
        chk("bp.carry", 32'(Carry_flag), 32'd1);

        // Reset during EXEC of addu $10,$1,$2
        Instr_valid = 1'b1; Instr = 32'h0022_5009;
        tick();
        Instr_valid = 1'b0;
        tick();
        chk("mr.op_exec", 32'(OP_ctrl), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("mr.ready", 32'(Instr_ready), 32'd1);
        chk("mr.done", 32'(Done), 32'd0);
        chk("mr.op", 32'(OP_ctrl), 32'd0);
        chk("mr.src1", Src_1, 32'd0);
        chk("mr.cnt", 32'(Instr_cnt), 32'd0);
        chk("mr.carry", 32'(Carry_flag), 32'd0);
        reg_chk("mr.r1", 5'd1, 32'd0);
        reg_chk("mr.r4", 5'd4, 32'd0);
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk("mr.done_after", 32'(Done), 32'd0);
        tick();
        chk("mr.done_after2", 32'(Done), 32'd0);
        reg_chk("mr.r10", 5'd10, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
